// File: rtl/mmio_bus_bridge_if.sv
// Signal bundle between a CPU-style requester and the MMIO/RAM bridge: CPU request bus,
// synchronous RAM port and the peripheral register slot port.
interface mmio_bus_bridge_if #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int N_PORTS = 4
) ();
    logic                        cpu_sel;
    logic                        cpu_load;
    logic [ADDR_W-1:0]           cpu_addr;
    logic [DATA_W-1:0]           cpu_wdata;
    logic                        cpu_clr;
    logic [DATA_W-1:0]           cpu_rdata;
    logic                        cpu_ready;
    logic                        cpu_stall;

    logic [ADDR_W-1:0]           ram_addr;
    logic [DATA_W-1:0]           ram_wdata;
    logic                        ram_we;
    logic [DATA_W-1:0]           ram_rdata;

    logic [N_PORTS*DATA_W-1:0]   mmio_rdata;
    logic [DATA_W-1:0]           mmio_wdata;
    logic [N_PORTS-1:0]          mmio_we;
    logic [N_PORTS-1:0]          mmio_re;

    modport slave (
        input  cpu_sel, cpu_load, cpu_addr, cpu_wdata, cpu_clr, ram_rdata, mmio_rdata,
        output cpu_rdata, cpu_ready, cpu_stall, ram_addr, ram_wdata, ram_we,
               mmio_wdata, mmio_we, mmio_re
    );

    modport master (
        output cpu_sel, cpu_load, cpu_addr, cpu_wdata, cpu_clr, ram_rdata, mmio_rdata,
        input  cpu_rdata, cpu_ready, cpu_stall, ram_addr, ram_wdata, ram_we,
               mmio_wdata, mmio_we, mmio_re
    );
endinterface

// File: rtl/mmio_bus_bridge.sv
// Routes single CPU transactions to a small window of peripheral register slots or to a
// synchronous RAM, and can sweep the whole RAM with a constant word while stalling the CPU.
module mmio_bus_bridge #(
    parameter int                  ADDR_W    = 12,
    parameter int                  DATA_W    = 16,
    parameter int                  N_PORTS   = 4,
    parameter int                  MMIO_BASE = 110,
    parameter int                  RAM_DEPTH = 4096,
    parameter logic [N_PORTS-1:0]  RO_MASK   = 4'b1110,
    parameter logic [DATA_W-1:0]   CLR_VALUE = '0
) (
    input  logic             clk,
    input  logic             res,
    mmio_bus_bridge_if.slave bus
);
    localparam int               CNT_W    = $clog2(RAM_DEPTH) + 1;
    localparam int               SLOT_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RAM_WAIT,
        DONE,
        CLEAR
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [31:0]         addr_ext;
    logic                mmio_hit;
    logic                ram_hit;
    logic [SLOT_W-1:0]   slot;
    logic [N_PORTS-1:0]  slot_onehot;
    logic [DATA_W-1:0]   slot_data;

    logic                ram_we_c;
    logic [ADDR_W-1:0]   ram_addr_c;
    logic [DATA_W-1:0]   ram_wdata_c;
    logic [N_PORTS-1:0]  mmio_we_c;
    logic [N_PORTS-1:0]  mmio_re_c;

    // The MMIO window is checked first so it shadows any RAM words underneath it.
    assign addr_ext    = 32'(bus.cpu_addr);
    assign mmio_hit    = (addr_ext >= 32'(MMIO_BASE)) && (addr_ext < 32'(MMIO_BASE + N_PORTS));
    assign ram_hit     = !mmio_hit && (addr_ext < 32'(RAM_DEPTH));
    assign slot        = SLOT_W'(addr_ext - 32'(MMIO_BASE));
    assign slot_onehot = N_PORTS'(1) << slot;
    assign slot_data   = bus.mmio_rdata[int'(slot)*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        ram_we_c    = 1'b0;
        ram_addr_c  = bus.cpu_addr;
        ram_wdata_c = bus.cpu_wdata;
        mmio_we_c   = '0;
        mmio_re_c   = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (bus.cpu_sel) begin
                    state_d = DONE;
                    if (mmio_hit) begin
                        if (bus.cpu_load) begin
                            mmio_re_c = slot_onehot;
                            rdata_d   = slot_data;
                        end else if (!RO_MASK[slot]) begin
                            mmio_we_c = slot_onehot;
                        end
                    end else if (ram_hit) begin
                        if (bus.cpu_load) begin
                            state_d = RAM_WAIT;
                        end else begin
                            ram_we_c = 1'b1;
                        end
                    end else if (bus.cpu_load) begin
                        rdata_d = '0;
                    end
                end
            end
            RAM_WAIT: begin
                rdata_d = bus.ram_rdata;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            CLEAR: begin
                ram_we_c    = 1'b1;
                ram_addr_c  = ADDR_W'(cnt_q);
                ram_wdata_c = CLR_VALUE;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are decoded from live inputs in IDLE, so reset has to mask them directly.
        if (res) begin
            ram_we_c  = 1'b0;
            mmio_we_c = '0;
            mmio_re_c = '0;
        end
    end

    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_ready  = (state_q == DONE);
    assign bus.cpu_stall  = (state_q == CLEAR);
    assign bus.ram_we     = ram_we_c;
    assign bus.ram_addr   = ram_addr_c;
    assign bus.ram_wdata  = ram_wdata_c;
    assign bus.mmio_wdata = bus.cpu_wdata;
    assign bus.mmio_we    = mmio_we_c;
    assign bus.mmio_re    = mmio_re_c;
endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Scoreboard bench for mmio_bus_bridge: a memory-array reference model predicts every
// completion, and an independent monitor pops and compares each cpu_ready pulse.
module tb_mmio_bus_bridge;
    localparam int               ADDR_W    = 12;
    localparam int               DATA_W    = 16;
    localparam int               N_PORTS   = 4;
    localparam int               MMIO_BASE = 110;
    localparam int               RAM_DEPTH = 2048;
    localparam logic [3:0]       RO_MASK   = 4'b1110;
    localparam logic [15:0]      CLR_VALUE = 16'hC1EA;
    localparam int               MEM_WORDS = 1 << ADDR_W;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        int                readyCyc;
    } exp_t;

    logic clk = 1'b0;
    logic res;
    int   cyc = 0;

    int   assertCount = 0;
    int   failCount   = 0;
    int   violations  = 0;
    int   strayStrobes = 0;

    logic [DATA_W-1:0] ramMem   [0:MEM_WORDS-1];
    logic [DATA_W-1:0] refMem   [0:MEM_WORDS-1];
    logic [DATA_W-1:0] slotVals [0:N_PORTS-1];
    logic [DATA_W-1:0] lastRdata = '0;
    exp_t              expQ [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mmio_bus_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_PORTS(N_PORTS)) bus ();

    mmio_bus_bridge #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .N_PORTS  (N_PORTS),
        .MMIO_BASE(MMIO_BASE),
        .RAM_DEPTH(RAM_DEPTH),
        .RO_MASK  (RO_MASK),
        .CLR_VALUE(CLR_VALUE)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    // Synchronous RAM seen by the bridge: write on we, read data one cycle after the address.
    always @(posedge clk) begin
        if (bus.ram_we) ramMem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ramMem[bus.ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!res && bus.cpu_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_ready", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("cpu_rdata", 32'(bus.cpu_rdata), 32'(e.rdata));
                checkOutput("ready_cycle", cyc, e.readyCyc);
            end
        end
    end

    always @(negedge clk) begin
        if ((bus.ram_we && (|bus.mmio_we)) || !$onehot0(bus.mmio_we) || !$onehot0(bus.mmio_re))
            violations++;
        if (res && (bus.ram_we || (|bus.mmio_we) || (|bus.mmio_re) || bus.cpu_ready || bus.cpu_stall))
            violations++;
    end

    task automatic driveSlots();
        for (int k = 0; k < N_PORTS; k++) bus.mmio_rdata[k*DATA_W +: DATA_W] = slotVals[k];
    endtask

    // Called at a negedge with the bridge idle; returns at a negedge with the bridge idle again.
    task automatic applyStimulus(input logic clr, input logic sel, input logic load,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        int                a;
        bit                isMmio, isRam, seen;
        int                lat, budget, clrIdx, clrGood, stallCycles;
        logic [N_PORTS-1:0] expWe, expRe;
        logic              expRamWe;
        exp_t              e;

        a       = int'(addr);
        isMmio  = (a >= MMIO_BASE) && (a < MMIO_BASE + N_PORTS);
        isRam   = !isMmio && (a < RAM_DEPTH);
        expWe   = '0;
        expRe   = '0;
        expRamWe = 1'b0;
        lat     = 1;

        if (clr) begin
            lat = RAM_DEPTH + 1;
            for (int i = 0; i < RAM_DEPTH; i++) refMem[i] = CLR_VALUE;
        end else if (isMmio) begin
            if (load) begin
                expRe[a-MMIO_BASE] = 1'b1;
                lastRdata = slotVals[a-MMIO_BASE];
            end else if (!RO_MASK[a-MMIO_BASE]) begin
                expWe[a-MMIO_BASE] = 1'b1;
            end
        end else if (isRam) begin
            if (load) begin
                lat = 2;
                lastRdata = refMem[a];
            end else begin
                expRamWe = 1'b1;
                refMem[a] = wdata;
            end
        end else if (load) begin
            lastRdata = '0;
        end
        e.rdata    = lastRdata;
        e.readyCyc = cyc + lat;

        bus.cpu_clr   = clr;
        bus.cpu_sel   = sel;
        bus.cpu_load  = load;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        expQ.push_back(e);
        #1;
        checkOutput("issue_ram_we", 32'(bus.ram_we), 32'(expRamWe));
        checkOutput("issue_mmio_we", 32'(bus.mmio_we), 32'(expWe));
        checkOutput("issue_mmio_re", 32'(bus.mmio_re), 32'(expRe));
        if (!clr && isRam) checkOutput("issue_ram_addr", 32'(bus.ram_addr), 32'(addr));
        if (expRamWe) checkOutput("issue_ram_wdata", 32'(bus.ram_wdata), 32'(wdata));
        if (|expWe) checkOutput("issue_mmio_wdata", 32'(bus.mmio_wdata), 32'(wdata));

        seen = 0;
        budget = lat + 4;
        clrIdx = 0;
        clrGood = 0;
        stallCycles = 0;
        while (!seen && budget > 0) begin
            @(negedge clk);
            if (clr) begin
                if (bus.cpu_stall) begin
                    stallCycles++;
                    if (bus.ram_we && int'(bus.ram_addr) == clrIdx && bus.ram_wdata == CLR_VALUE
                        && bus.mmio_we == '0 && bus.mmio_re == '0)
                        clrGood++;
                    clrIdx++;
                end
            end else if (bus.ram_we || (|bus.mmio_we) || (|bus.mmio_re)) begin
                strayStrobes++;
            end
            if (bus.cpu_ready) seen = 1;
            budget--;
        end
        if (!seen) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            expQ.delete();
        end
        bus.cpu_sel = 1'b0;
        bus.cpu_clr = 1'b0;
        if (clr) begin
            checkOutput("clear_write_cycles", clrGood, RAM_DEPTH);
            checkOutput("clear_stall_cycles", stallCycles, RAM_DEPTH);
        end
        @(negedge clk);
        checkOutput("ready_one_cycle", 32'(bus.cpu_ready), 32'd0);
    endtask

    task automatic resetMidClear(input int abortAt);
        int budget;
        bit hit;
        budget = abortAt + 10;
        hit = 0;
        bus.cpu_clr = 1'b1;
        bus.cpu_sel = 1'b0;
        while (!hit && budget > 0) begin
            @(negedge clk);
            if (bus.cpu_stall && int'(bus.ram_addr) == abortAt) hit = 1;
            budget--;
        end
        checkOutput("abort_point_reached", 32'(hit), 32'd1);
        bus.cpu_clr = 1'b0;
        #1 res = 1'b1;
        #1;
        checkOutput("abort_stall", 32'(bus.cpu_stall), 32'd0);
        checkOutput("abort_ram_we", 32'(bus.ram_we), 32'd0);
        checkOutput("abort_ready", 32'(bus.cpu_ready), 32'd0);
        checkOutput("abort_rdata", 32'(bus.cpu_rdata), 32'd0);
        for (int i = 0; i < abortAt; i++) refMem[i] = CLR_VALUE;
        lastRdata = '0;
        expQ.delete();
        @(negedge clk);
        res = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r, a;
        logic [DATA_W-1:0] w;

        for (int i = 0; i < MEM_WORDS; i++) begin
            ramMem[i] = DATA_W'(i * 7 + 3);
            refMem[i] = DATA_W'(i * 7 + 3);
        end
        for (int k = 0; k < N_PORTS; k++) slotVals[k] = DATA_W'(16'h1000 + k);
        slotVals[1] = 16'h000A;
        driveSlots();

        res           = 1'b1;
        bus.cpu_clr   = 1'b0;
        bus.cpu_sel   = 1'b1;
        bus.cpu_load  = 1'b0;
        bus.cpu_addr  = 12'd5;
        bus.cpu_wdata = 16'h5555;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_ready", 32'(bus.cpu_ready), 32'd0);
        checkOutput("reset_stall", 32'(bus.cpu_stall), 32'd0);
        checkOutput("reset_rdata", 32'(bus.cpu_rdata), 32'd0);
        checkOutput("reset_ram_we", 32'(bus.ram_we), 32'd0);
        bus.cpu_sel = 1'b0;
        res = 1'b0;

        $display("[TB] directed transactions");
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd5, 16'hBEEF);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd5, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd111, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd110, 16'h1234);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd111, 16'h1234);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd5, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd4095, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd2047, 16'h7E57);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd2047, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd2048, 16'hDEAD);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd109, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd114, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd113, 16'h0000);

        $display("[TB] full clear with a competing request");
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd200, 16'hA200);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'd7, 16'h4444);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd200, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd0, 16'h0000);

        $display("[TB] reset during clear");
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd200, 16'hB200);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd100, 16'hB100);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd99, 16'hB099);
        resetMidClear(100);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd200, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd100, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'd99, 16'h0000);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 80; n++) begin
            for (int k = 0; k < N_PORTS; k++) slotVals[k] = DATA_W'($urandom);
            driveSlots();
            r = $urandom_range(0, 9);
            if (r <= 3)      a = $urandom_range(0, 31);
            else if (r <= 5) a = $urandom_range(MMIO_BASE - 2, MMIO_BASE + N_PORTS + 1);
            else if (r == 6) a = $urandom_range(RAM_DEPTH, MEM_WORDS - 1);
            else if (r == 7) a = $urandom_range(RAM_DEPTH - 8, RAM_DEPTH - 1);
            else             a = $urandom_range(0, 31);
            w = DATA_W'($urandom);
            applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), ADDR_W'(a), w);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);
        checkOutput("strobe_invariants", violations, 32'd0);
        checkOutput("stray_strobes", strayStrobes, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
